// File: rtl/ascon_text_block_feeder.sv
// Packs a 32-bit word stream into 128-bit ASCON blocks and strobes them into the datapath.
// The last block is always issued (possibly empty) and uses the datapath's split padding layout.
module ascon_text_block_feeder #(
  parameter int LEN_W   = 32,
  parameter int MIN_GAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_sel_i,
  input  logic [LEN_W-1:0] text_length_i,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             stage_ready,
  output logic             process_en,
  output logic             process_mode_sel,
  output logic [LEN_W-1:0] text_length,
  output logic [LEN_W-1:0] text_position,
  output logic [127:0]     data_in,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, FILL, ISSUE, GAP, FINISH} state_t;

  localparam logic [3:0] GAP_LAST = (MIN_GAP == 0) ? 4'd0 : 4'(MIN_GAP - 1);

  state_t         state, state_nxt;
  logic [LEN_W-1:0] rem;
  logic           full, xfer, last_word;
  logic [4:0]     nb;
  logic [2:0]     need, wcnt;
  logic [3:0]     gcnt;
  logic [127:0]   raw, raw_nxt;

  assign rem       = text_length - text_position;
  assign full      = rem >= LEN_W'(16);
  assign nb        = full ? 5'd16 : rem[4:0];
  assign need      = 3'((nb + 5'd3) >> 2);
  assign s_ready   = (state == FILL) && (wcnt < need);
  assign xfer      = s_valid && s_ready;
  assign last_word = xfer && ((wcnt + 3'd1) == need);
  assign process_en = (state == ISSUE) && stage_ready;
  assign busy      = (state != IDLE) && (state != FINISH);
  assign done      = (state == FINISH);

  // raw holds the block bytes in stream order, MSB-first; unused bytes stay zero
  always_comb begin
    raw_nxt = raw;
    if (xfer) begin
      for (int j = 0; j < 4; j++) begin
        if (4 * int'(wcnt) + j < int'(nb))
          raw_nxt[127 - 8 * (4 * int'(wcnt) + j) -: 8] = s_data[31 - 8 * j -: 8];
      end
    end
  end

  // Short blocks: first up-to-8 bytes right-justified in the upper half, rest right-justified below
  function automatic logic [127:0] pack(input logic [127:0] r, input logic [4:0] n);
    logic [6:0] sh;
    sh = 7'd64 - {1'b0, n[2:0], 3'b000};
    if (n[4])       return r;
    if (n < 5'd8)   return {r[127:64] >> sh, 64'd0};
    return {r[127:64], r[63:0] >> sh};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = FILL;
      FILL:   if (need == 3'd0 || last_word) state_nxt = ISSUE;
      ISSUE:  if (stage_ready) state_nxt = !full ? FINISH : (MIN_GAP == 0) ? FILL : GAP;
      GAP:    if (gcnt == GAP_LAST) state_nxt = FILL;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      process_mode_sel <= 1'b0;
      text_length      <= '0;
      text_position    <= '0;
      data_in          <= '0;
      raw              <= '0;
      wcnt             <= '0;
      gcnt             <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          process_mode_sel <= mode_sel_i;
          text_length      <= text_length_i;
          text_position    <= '0;
        end
        FILL: begin
          if (xfer) begin
            raw  <= raw_nxt;
            wcnt <= wcnt + 3'd1;
          end
          if (state_nxt == ISSUE) data_in <= pack(raw_nxt, nb);
        end
        ISSUE: if (stage_ready && full) text_position <= text_position + LEN_W'(16);
        GAP:   gcnt <= gcnt + 4'd1;
        default: ;
      endcase
      if (state_nxt == FILL && state != FILL) begin
        raw  <= '0;
        wcnt <= '0;
      end
      if (state_nxt == GAP && state != GAP) gcnt <= '0;
    end
  end
endmodule

// File: tb/tb_ascon_text_block_feeder.sv
// Bench for the block feeder: directed and randomized messages checked against a byte-level model.
module tb_ascon_text_block_feeder;
  localparam int GAPC = 3;

  logic         clk = 0, rst = 1, start = 0, mode_sel_i = 0;
  logic [31:0]  text_length_i = 0, s_data = 0;
  logic         s_valid = 0, s_ready, stage_ready = 1;
  logic         process_en, process_mode_sel, busy, done;
  logic [31:0]  text_length, text_position;
  logic [127:0] data_in;

  int errors = 0, checks = 0;
  logic [31:0] wq[$];

  ascon_text_block_feeder #(.LEN_W(32), .MIN_GAP(GAPC)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_sel_i(mode_sel_i),
    .text_length_i(text_length_i), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .stage_ready(stage_ready), .process_en(process_en),
    .process_mode_sel(process_mode_sel), .text_length(text_length),
    .text_position(text_position), .data_in(data_in), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rand(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  function automatic logic [7:0] byte_at(input int b);
    logic [31:0] w;
    w = wq[b / 4];
    return w[31 - 8 * (b % 4) -: 8];
  endfunction

  // Expected block k straight from the byte placement rules
  function automatic logic [127:0] exp_blk(input int len, input int k);
    logic [127:0] d;
    int pos, nb, off;
    d = '0;
    pos = 16 * k;
    nb = (len - pos >= 16) ? 16 : len - pos;
    for (int i = 0; i < nb; i++) begin
      if (nb == 16)   off = 8 * (15 - i);
      else if (nb < 8) off = 64 + 8 * (nb - 1 - i);
      else if (i < 8) off = 64 + 8 * (7 - i);
      else            off = 8 * (nb - 1 - i);
      d[off +: 8] = byte_at(pos + i);
    end
    return d;
  endfunction

  // stall >= 0: hold stage_ready low that many cycles once the first block is full; < 0: random
  task automatic run_msg(input int len, input logic mode, input int vpct, input int stall);
    int nblk, nw, wi, bi, cyc, since, st, first_full;
    bit dn;
    nblk = len / 16 + 1; nw = (len + 3) / 4;
    wi = 0; bi = 0; cyc = 0; since = -1; st = stall; dn = 0;
    first_full = (nw < 4) ? nw : 4;
    start = 1; mode_sel_i = mode; text_length_i = len;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", busy, 1'b1);
    while (!dn && cyc < 3000) begin
      s_valid = ($urandom_range(99) < vpct);
      s_data  = (wi < nw) ? wq[wi] : $urandom;
      if (stall < 0) stage_ready = $urandom_range(1);
      else if (st > 0 && wi >= first_full) begin stage_ready = 0; st--; end
      else stage_ready = 1;
      @(negedge clk);
      if (s_ready) begin
        if (since >= 0) begin chk("gap_cycles", since, GAPC); since = -1; end
      end else if (since >= 0) since++;
      if (s_valid && s_ready) begin
        chk("no_extra_word", wi < nw, 1'b1);
        wi++;
      end
      if (process_en) begin
        chk("pe_needs_stage_ready", stage_ready, 1'b1);
        chk("no_extra_block", bi < nblk, 1'b1);
        chk("blk_data", data_in, exp_blk(len, bi));
        chk("blk_pos", text_position, 32'(16 * bi));
        chk("blk_len", text_length, 32'(len));
        chk("blk_mode", process_mode_sel, mode);
        bi++;
        since = 0;
      end
      if (done) begin
        chk("busy_low_at_done", busy, 1'b0);
        dn = 1;
      end else if (bi == 0 || !dn) chk("busy_in_msg", busy, 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", dn, 1'b1);
    chk("words_total", wi, nw);
    chk("blocks_total", bi, nblk);
    s_valid = 0; stage_ready = 1;
    @(negedge clk);
    chk("done_one_cycle", {done, busy, s_ready}, 3'b000);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, data_in, '0);
    chk({tag, "_pos"}, text_position, '0);
    chk({tag, "_len"}, text_length, '0);
    chk({tag, "_ctl"}, {process_en, process_mode_sel, busy, done, s_ready}, 5'b0);
  endtask

  initial begin
    int wi, cyc, len;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 0;
    @(posedge clk); #1;

    // empty message: one zero block, no words
    fill_rand(0);
    run_msg(0, 1'b0, 100, 0);

    // exactly one full block plus an empty final block
    wq = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    chk("model_len16", exp_blk(16, 0), 128'h000102030405060708090A0B0C0D0E0F);
    run_msg(16, 1'b0, 100, 0);
    chk("len16_final_zero", data_in, '0);

    // 5-byte message, trailing bytes of the second word discarded
    wq = '{32'h11223344, 32'h55AAAAAA};
    run_msg(5, 1'b0, 100, 0);
    chk("len5_layout", data_in, 128'h0000001122334455_0000000000000000);

    // decrypt with a stalled datapath at the first block
    fill_rand(5);
    run_msg(20, 1'b1, 100, 4);

    // bursty source, 8 + 4 byte final split
    fill_rand(11);
    run_msg(44, 1'b0, 50, 0);

    // random lengths, modes, source and sink back-pressure
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(70);
      fill_rand((len + 3) / 4);
      run_msg(len, 1'($urandom_range(1)), 70, -1);
    end

    // abort during the second block's fill
    fill_rand(11);
    start = 1; mode_sel_i = 1; text_length_i = 44; s_valid = 1;
    @(posedge clk); #1;
    start = 0;
    wi = 0; cyc = 0;
    while (wi < 6 && cyc < 200) begin
      s_data = wq[wi];
      @(negedge clk);
      if (s_valid && s_ready) wi++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_reached", wi, 6);
    s_valid = 0; rst = 1;
    @(posedge clk); #1;
    chk_zero("abort");
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", {done, busy}, 2'b00);
    end
    @(posedge clk); #1;

    wq = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    run_msg(16, 1'b0, 100, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ascon_text_block_feeder.md
Name: ascon_text_block_feeder

Overview:
- Upstream stage of the ASCON encrypt/decrypt datapath.
- Accepts plaintext or ciphertext as a 32-bit word stream with a valid/ready handshake, and assembles it into 128-bit blocks.
- For each block, drives data_in, text_length, text_position and process_mode_sel, then pulses process_en.
- Always issues one final (possibly empty) block so the datapath can apply padding.

Parameters:
- LEN_W, 32, width of text_length and text_position.
- MIN_GAP, 1, minimum idle cycles between consecutive process_en pulses (range 0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a message (ignored unless idle)
- mode_sel_i  in  1  0 encrypt, 1 decrypt; sampled on start
- text_length_i  in  LEN_W  message length in bytes; sampled on start
- s_data  in  32  input word; first byte in [31:24]
- s_valid  in  1  s_data valid
- s_ready  out  1  feeder accepts word
- stage_ready  in  1  datapath can take a block (permutation path free)
- process_en  out  1  one-cycle block strobe
- process_mode_sel  out  1  registered mode
- text_length  out  LEN_W  registered length
- text_position  out  LEN_W  byte offset of the current block
- data_in  out  128  block data
- busy  out  1  message in progress
- done  out  1  one-cycle pulse after the final block is issued

Behaviour:
- Reset (rst high at a clk edge): all outputs 0; FSM in IDLE; counters cleared. Reset mid-message aborts with no done pulse.
- Clock and reset: already decided — one clock; reset is synchronous and active-high.
- FSM states: IDLE, FILL, ISSUE, GAP, FINISH.
- IDLE:
  - On start: latch mode and length; text_position=0; busy=1; go to FILL.
  - start while busy is ignored.
- Per-block byte count:
  - rem = text_length - text_position.
  - Block byte count nb = 16 if rem>=16, else rem.
  - Words needed = ceil(nb/4).
- FILL:
  - s_ready=1 until the word count for the current block is reached.
  - Transfer occurs when s_valid && s_ready.
  - Words fill the block MSB-first: word0 -> [127:96], ..., word3 -> [31:0].
  - Bytes beyond nb in the last word are discarded.
  - When the word count is reached (immediately if 0), go to ISSUE.
- Final-block packing (rem<16), matching the datapath convention:
  - If rem<8: the rem bytes occupy data_in[64+8*rem-1:64], in stream order, right-justified; all other bits 0.
  - If 8<=rem<16: the first 8 bytes go in [127:64]; the remaining rem-8 bytes are right-justified in [8*(rem-8)-1:0]; all other bits 0.
  - If rem==0: data_in=0.
- ISSUE:
  - Wait for stage_ready=1, then assert process_en for exactly one cycle.
  - data_in, text_position and mode stay stable in that cycle and remain held until the next block loads.
  - If rem>=16: text_position += 16 on the cycle after the pulse; go to GAP.
  - Else: go to FINISH.
- GAP:
  - Count MIN_GAP cycles with s_ready=0, then go to FILL.
  - If MIN_GAP=0, go directly to FILL.
- FINISH: done=1 for one cycle; busy=0; go to IDLE.
- Block and word counts:
  - Total blocks = floor(len/16)+1.
  - Total words accepted = ceil(len/4).
  - If len%16==0, the final block consumes no words.
- s_ready timing:
  - s_ready is never high outside FILL.
  - s_ready is combinational from state and word count only; it never depends on s_valid.
- Back-pressure: s_valid low holds FILL indefinitely; stage_ready low holds ISSUE indefinitely. No data is lost either way.
- Arithmetic: text_position is LEN_W bits and never exceeds text_length; the rem comparison is unsigned.

Test Plan:
- len=0, encrypt: start -> no s_ready; one process_en with text_position=0 and data_in=0; done next cycle.
- len=16, words 00010203, 04050607, 08090A0B, 0C0D0E0F:
  - Block 0: data_in=000102030405060708090A0B0C0D0E0F, position 0.
  - Block 1: position 16, data_in=0, with no words consumed.
- len=5, words 11223344, 55AAAAAA -> data_in[127:64]=0000001122334455, low half 0; exactly 2 words accepted.
- len=20, decrypt, MIN_GAP=3, stage_ready low for 4 cycles at the first block:
  - process_en is delayed until stage_ready rises.
  - Exactly 3 gap cycles separate the blocks.
  - Second block has position 16 and 4 bytes right-justified at [95:64].
  - process_mode_sel=1 on both pulses.
- s_valid toggled randomly on len=44:
  - 11 words accepted; blocks issued at positions 0, 16, 32.
  - The final block has 8 bytes in [127:64] and 4 bytes in [31:0].
- Reset during FILL of block 2: all outputs 0 next cycle, no done pulse; a new start then behaves as from reset.
